// File: rtl/coeff_bank_streamer.sv
// coeff_bank_streamer
// Holds N_SEG-1 programmable count thresholds and an N_SEG x N_COEF coefficient
// bank. Each accepted ADC count selects a segment; that segment's coefficients
// are then streamed one per beat over a valid/ready interface.

module coeff_bank_streamer #(
   parameter int CNT_W  = 21,
   parameter int COEF_W = 32,
   parameter int N_COEF = 10,
   parameter int N_SEG  = 4,
   parameter int SEG_W  = 2,
   parameter int IDX_W  = $clog2(N_COEF),
   parameter int ADDR_W = $clog2(N_SEG * N_COEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CNT_W-1:0]  adc_count,
   input  logic              adc_valid,
   output logic              adc_ready,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [COEF_W-1:0] cfg_wdata,
   input  logic              thr_we,
   input  logic [SEG_W-1:0]  thr_idx,
   input  logic [CNT_W-1:0]  thr_wdata,
   output logic              coef_valid,
   input  logic              coef_ready,
   output logic [COEF_W-1:0] coef_data,
   output logic [IDX_W-1:0]  coef_idx,
   output logic [SEG_W-1:0]  coef_seg,
   output logic              coef_last
);

   localparam int N_WORDS = N_SEG * N_COEF;
   localparam int N_THR   = N_SEG - 1;

   typedef enum logic [1:0] {
      IDLE,
      SEL,
      STREAM
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [COEF_W-1:0]   bank [N_WORDS];
   logic [CNT_W-1:0]    thr  [N_THR];

   logic [SEG_W-1:0]    seg_sel;
   logic [SEG_W-1:0]    seg_q;
   logic                accept;
   logic                load_first;
   logic                advance;
   logic                cfg_hit;
   logic                thr_hit;
   logic [SEG_W-1:0]    rd_seg;
   logic [IDX_W-1:0]    rd_idx;
   logic [ADDR_W-1:0]   rd_addr;

   assign advance   = coef_valid && coef_ready;
   assign coef_last = coef_valid && (coef_idx == IDX_W'(N_COEF - 1));
   assign cfg_hit   = cfg_we && (int'(cfg_addr) < N_WORDS);
   assign thr_hit   = thr_we && (int'(thr_idx) < N_THR);

   // Segment select: smallest k with adc_count below thr[k], else the top segment.
   always_comb begin
      // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
      seg_sel = SEG_W'(N_SEG - 1);
      for (int k = N_THR - 1; k >= 0; k--) begin
         if (adc_count < thr[k]) seg_sel = SEG_W'(k);
      end
   end

   // Bank read address: beat 0 of the latched segment, or the next beat of the current burst.
   always_comb begin
      rd_seg = coef_seg;
      rd_idx = coef_idx + IDX_W'(1);
      if (load_first) begin
         rd_seg = seg_q;
         rd_idx = '0;
      end
      rd_addr = ADDR_W'(int'(rd_seg) * N_COEF + int'(rd_idx));
   end

   // Configuration storage: coefficient bank and thresholds, writable in any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the bank sits in flops with a full reset because it must read back as zero after reset; a RAM macro could not provide that.
         for (int i = 0; i < N_WORDS; i++) bank[i] <= '0;
         for (int k = 0; k < N_THR; k++) thr[k] <= CNT_W'((k + 1) * ((1 << (CNT_W - 2)) - 1));
      end else begin
         // NOTE: non-blocking writes here are what make a beat loaded on the same edge see the old word.
         if (cfg_hit) bank[cfg_addr] <= cfg_wdata;
         if (thr_hit) thr[thr_idx]   <= thr_wdata;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SEL;
         SEL:     state_nxt = STREAM;
         STREAM:  if (advance && coef_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: ready while idle, first-beat load on the first STREAM cycle.
   always_comb begin
      adc_ready  = (state == IDLE);
      accept     = adc_valid && (state == IDLE);
      load_first = (state == STREAM) && !coef_valid;
   end

   // Beat register: loads beat 0, advances on handshake, holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q      <= '0;
         coef_valid <= 1'b0;
         coef_data  <= '0;
         coef_idx   <= '0;
         coef_seg   <= '0;
      end else begin
         if (accept) seg_q <= seg_sel;
         if (load_first) begin
            coef_valid <= 1'b1;
            coef_idx   <= '0;
            coef_seg   <= seg_q;
            coef_data  <= bank[rd_addr];
         end else if (advance) begin
            if (coef_last) begin
               coef_valid <= 1'b0;
            end else begin
               coef_idx  <= rd_idx;
               coef_data <= bank[rd_addr];
            end
         end
      end
   end

endmodule
